// File: rtl/ras_circ_pkg.sv
// Frontend return-address-stack types and the per-cycle request decoder.
// Request priority is decided here so the RAS datapath only sees one operation.
package ras_circ_pkg;

    localparam int unsigned RasVlenDefault = 32;

    // Entry view consumed by the fetch-address mux.
    typedef struct packed {
        logic                      valid;
        logic [RasVlenDefault-1:0] ra;
    } ras_t;

    typedef enum logic [2:0] {
        OpIdle,
        OpFlush,
        OpRestore,
        OpPush,
        OpPop,
        OpSwap
    } ras_op_e;

    // Collapse the request lines into a single operation, highest priority first.
    // A pop on an empty stack is dropped; push+pop on an empty stack acts as a push.
    function automatic ras_op_e ras_decode(input logic flush, input logic restore,
                                           input logic push, input logic pop,
                                           input logic empty);
        ras_op_e op;
        op = OpIdle;
        if (flush) begin
            op = OpFlush;
        end else if (restore) begin
            op = OpRestore;
        end else if (push && pop && !empty) begin
            op = OpSwap;
        end else if (push) begin
            op = OpPush;
        end else if (pop && !empty) begin
            op = OpPop;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_circ.sv
// Circular-buffer return-address stack with checkpoint export and restore.
// On overflow the oldest entry is overwritten; the newest is always kept.
module ras_circ
    import ras_circ_pkg::*;
#(
    parameter int unsigned VLEN  = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_bp_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VLEN-1:0]  data_i,
    output logic             valid_o,
    output logic [VLEN-1:0]  data_o,
    output logic [PTR_W-1:0] ckpt_ptr_o,
    output logic [CNT_W-1:0] ckpt_cnt_o,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [CNT_W-1:0] restore_cnt_i,
    output logic             overflow_o
);

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [CNT_W-1:0] cnt;
    } ras_ckpt_t;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PtrRst = PTR_W'(DEPTH - 1);

    logic [VLEN-1:0] entries_q [DEPTH];
    logic [VLEN-1:0] entries_d [DEPTH];
    ras_ckpt_t       ckpt_q, ckpt_d;
    logic            overflow_q, overflow_d;
    ras_op_e         op;

    assign op = ras_decode(flush_bp_i, restore_i, push_i, pop_i, ckpt_q.cnt == '0);

    always_comb begin
        entries_d  = entries_q;
        ckpt_d     = ckpt_q;
        overflow_d = 1'b0;
        unique case (op)
            OpIdle: ;
            OpFlush: ckpt_d.cnt = '0;
            OpRestore: begin
                ckpt_d.ptr = restore_ptr_i;
                ckpt_d.cnt = (restore_cnt_i > CntMax) ? CntMax : restore_cnt_i;
            end
            OpPush: begin
                // Pointer wraps naturally because DEPTH is a power of two.
                ckpt_d.ptr            = ckpt_q.ptr + PTR_W'(1);
                entries_d[ckpt_d.ptr] = data_i;
                if (ckpt_q.cnt == CntMax) begin
                    overflow_d = 1'b1;
                end else begin
                    ckpt_d.cnt = ckpt_q.cnt + CNT_W'(1);
                end
            end
            OpPop: begin
                ckpt_d.ptr = ckpt_q.ptr - PTR_W'(1);
                ckpt_d.cnt = ckpt_q.cnt - CNT_W'(1);
            end
            OpSwap: entries_d[ckpt_q.ptr] = data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q  <= '{default: '0};
            ckpt_q.ptr <= PtrRst;
            ckpt_q.cnt <= '0;
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            ckpt_q     <= ckpt_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_o     = entries_q[ckpt_q.ptr];
    assign valid_o    = (ckpt_q.cnt != '0);
    assign ckpt_ptr_o = ckpt_q.ptr;
    assign ckpt_cnt_o = ckpt_q.cnt;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ras_circ.sv
// Self-checking bench for ras_circ: directed scenarios plus randomized traffic
// compared every cycle against a behavioural stack model.
module tb_ras_circ;

    localparam int DEPTH = 4;
    localparam int VLEN  = 32;

    logic            clk = 1'b0;
    logic            rst, flush, push, pop, restore;
    logic [VLEN-1:0] din;
    logic [1:0]      rptr;
    logic [2:0]      rcnt;
    logic            valid;
    logic [VLEN-1:0] dout;
    logic [1:0]      cptr;
    logic [2:0]      ccnt;
    logic            ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [31:0] m_ent [DEPTH];
    int          m_tos, m_cnt;
    logic        m_ovf;

    always #5 clk = ~clk;

    ras_circ #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_bp_i    (flush),
        .push_i        (push),
        .pop_i         (pop),
        .data_i        (din),
        .valid_o       (valid),
        .data_o        (dout),
        .ckpt_ptr_o    (cptr),
        .ckpt_cnt_o    (ccnt),
        .restore_i     (restore),
        .restore_ptr_i (rptr),
        .restore_cnt_i (rcnt),
        .overflow_o    (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
            m_tos = DEPTH - 1;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (flush) begin
                m_cnt = 0;
            end else if (restore) begin
                m_tos = int'(rptr);
                m_cnt = (int'(rcnt) > DEPTH) ? DEPTH : int'(rcnt);
            end else if (push && pop && m_cnt != 0) begin
                m_ent[m_tos] = din;
            end else if (push) begin
                if (m_cnt == DEPTH) m_ovf = 1'b1;
                m_tos = (m_tos + 1) % DEPTH;
                m_ent[m_tos] = din;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (pop && m_cnt != 0) begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
        end
    endtask

    task automatic check_model();
        check("valid", 32'(valid), 32'(m_cnt != 0));
        check("data", dout, m_ent[m_tos]);
        check("ptr", 32'(cptr), 32'(m_tos));
        check("cnt", 32'(ccnt), 32'(m_cnt));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model on the edge, check #1 later.
    task automatic drive(input logic r, input logic f, input logic rs, input logic pu,
                         input logic po, input logic [31:0] d,
                         input logic [1:0] rp, input logic [2:0] rc);
        rst = r; flush = f; restore = rs; push = pu; pop = po;
        din = d; rptr = rp; rcnt = rc;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 2'd0, 3'd0);
    endtask

    task automatic do_push(input logic [31:0] d);
        drive(0, 0, 0, 1, 0, d, 2'd0, 3'd0);
    endtask

    task automatic do_pop();
        drive(0, 0, 0, 0, 1, 32'h0, 2'd0, 3'd0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 32'h0, 2'd0, 3'd0);
    endtask

    int ck_ptr, ck_cnt;

    initial begin
        rst = 1'b1; flush = 1'b0; restore = 1'b0; push = 1'b0; pop = 1'b0;
        din = '0; rptr = '0; rcnt = '0;
        for (int i = 0; i < DEPTH; i++) m_ent[i] = 'x;
        m_tos = 0; m_cnt = 0; m_ovf = 1'b0;

        // Reset state
        do_reset();
        check("rst_ptr", 32'(cptr), 32'd3);
        check("rst_cnt", 32'(ccnt), 32'd0);
        check("rst_data", dout, 32'h0);

        // Basic LIFO
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        check("lifo_top", dout, 32'h300);
        check("lifo_cnt3", 32'(ccnt), 32'd3);
        do_pop();  check("lifo_pop1", dout, 32'h200);
        do_pop();  check("lifo_pop2", dout, 32'h100);
        do_pop();  check("lifo_empty", 32'(valid), 32'd0);

        // Overflow: the fifth push overwrites the oldest entry
        do_reset();
        for (int i = 1; i <= 5; i++) do_push(32'(i * 16));
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_cnt", 32'(ccnt), 32'd4);
        check("ovf_top", dout, 32'h50);
        idle();
        check("ovf_clear", 32'(ovf), 32'd0);
        do_pop(); check("ovf_pop1", dout, 32'h40);
        do_pop(); check("ovf_pop2", dout, 32'h30);
        do_pop(); check("ovf_pop3", dout, 32'h20);
        do_pop(); check("ovf_drained", 32'(valid), 32'd0);

        // Underflow is ignored
        do_reset();
        do_pop(); do_pop();
        check("udf_ptr", 32'(cptr), 32'd3);
        check("udf_cnt", 32'(ccnt), 32'd0);

        // Push+pop replaces the top in place
        do_reset();
        do_push(32'h100); do_push(32'h200);
        drive(0, 0, 0, 1, 1, 32'h900, 2'd0, 3'd0);
        check("swap_top", dout, 32'h900);
        check("swap_cnt", 32'(ccnt), 32'd2);
        check("swap_ptr", 32'(cptr), 32'd1);
        do_pop(); check("swap_pop", dout, 32'h100);
        // Push+pop on an empty stack behaves as a push
        do_reset();
        drive(0, 0, 0, 1, 1, 32'h77, 2'd0, 3'd0);
        check("swap_empty_cnt", 32'(ccnt), 32'd1);

        // Checkpoint / restore
        do_reset();
        do_push(32'hA0); do_push(32'hB0);
        ck_ptr = m_tos; ck_cnt = m_cnt;
        do_push(32'hC0); do_pop(); do_pop();
        drive(0, 0, 1, 0, 0, 32'h0, 2'(ck_ptr), 3'(ck_cnt));
        check("rest_data", dout, 32'hB0);
        check("rest_cnt", 32'(ccnt), 32'd2);
        drive(0, 0, 1, 0, 0, 32'h0, 2'd1, 3'd7);
        check("rest_clamp", 32'(ccnt), 32'd4);

        // Priority: flush beats restore and push
        drive(0, 1, 1, 1, 0, 32'h55, 2'd3, 3'd2);
        check("prio_cnt", 32'(ccnt), 32'd0);
        check("prio_ptr", 32'(cptr), 32'd1);

        // Reset mid-sequence
        do_push(32'h1); do_push(32'h2); do_push(32'h3);
        do_reset();
        check("rst_mid_ptr", 32'(cptr), 32'd3);
        check("rst_mid_data", dout, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned p;
            logic r, f, rs, pu, po;
            p  = $urandom_range(0, 99);
            r  = (p == 0);
            f  = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 6);
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            drive(r, f, rs, pu, po, $urandom, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
